// File: rtl/pc_gen_pkg.sv
// Shared fetch-front-end types: redirect channel indices, PC generator
// states and the BTB entry layout.
package pc_gen_pkg;

    localparam int REDIR_TRAP   = 0;
    localparam int REDIR_CSR    = 1;
    localparam int REDIR_BRANCH = 2;

    localparam int PKG_XLEN = 64;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pcg_state_e;

    typedef struct packed {
        logic [PKG_XLEN-1:0] tag;
        logic [PKG_XLEN-1:0] target;
        logic                valid;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the current
// request PC, registered training write (same-cycle reads see old data).
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] target_o,
    input  logic            train_valid_i,
    input  logic [XLEN-1:0] train_pc_i,
    input  logic [XLEN-1:0] train_target_i
);

    localparam int IW = $clog2(BTB_ENTRIES);

    btb_entry_t ent_q [BTB_ENTRIES];

    logic [IW-1:0]       rd_idx;
    logic [IW-1:0]       wr_idx;
    logic [PKG_XLEN-1:0] rd_tag;
    btb_entry_t          rd_ent;
    btb_entry_t          wr_ent;
    logic                unused_low;

    assign rd_idx = lookup_pc_i[IW+1:2];
    assign wr_idx = train_pc_i[IW+1:2];
    assign rd_tag = PKG_XLEN'(lookup_pc_i >> (IW + 2));
    assign rd_ent = ent_q[rd_idx];

    assign hit_o    = rd_ent.valid && (rd_ent.tag == rd_tag);
    assign target_o = XLEN'(rd_ent.target);

    always_comb begin
        wr_ent        = '0;
        wr_ent.tag    = PKG_XLEN'(train_pc_i >> (IW + 2));
        wr_ent.target = PKG_XLEN'(train_target_i);
        wr_ent.valid  = 1'b1;
    end

    // Low two PC bits never select or tag an entry.
    assign unused_low = ^{lookup_pc_i[1:0], train_pc_i[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else if (train_valid_i) begin
            ent_q[wr_idx] <= wr_ent;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch PC generator with prioritised redirects and a
// valid/ready request handshake. Optional BTB: define PCGEN_BTB_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter int              NUM_REDIRECT = 3,
    parameter logic [XLEN-1:0] RESET_PC     = 64'h0000_0000_8000_0000,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REDIRECT-1:0]            redirect_valid,
    input  logic [NUM_REDIRECT-1:0][XLEN-1:0]  redirect_pc,
    input  logic                               pc_ready,
    output logic                               pc_valid,
    output logic [XLEN-1:0]                    pc,
    output logic                               pc_kill,
    output logic                               pred_taken,
    input  logic                               train_valid,
    input  logic [XLEN-1:0]                    train_pc,
    input  logic [XLEN-1:0]                    train_target
);

    pcg_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            pend_v_q, pend_v_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic            redir_any;
    logic [XLEN-1:0] win_pc;
    logic            hs;
    logic            stall;
    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;
    logic            use_pred;

    assign redir_any = |redirect_valid;
    assign hs        = valid_q && pc_ready;
    assign stall     = valid_q && !pc_ready;

    // Scan high to low so the lowest asserted index ends up winning.
    always_comb begin
        win_pc = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                win_pc = {redirect_pc[i][XLEN-1:1], 1'b0};
            end
        end
    end

`ifdef PCGEN_BTB_EN
    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc_i    (pc_q),
        .hit_o          (btb_hit),
        .target_o       (btb_tgt),
        .train_valid_i  (train_valid),
        .train_pc_i     (train_pc),
        .train_target_i (train_target)
    );
`else
    logic unused_train;

    assign btb_hit      = 1'b0;
    assign btb_tgt      = '0;
    assign unused_train = ^{train_valid, train_pc, train_target};
`endif

    assign use_pred   = hs && !redir_any && !pend_v_q && btb_hit;
    assign pc_kill    = hs && (redir_any || pend_v_q);
    assign pred_taken = use_pred;
    assign pc         = pc_q;
    assign pc_valid   = valid_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            BOOT: begin
                valid_d = 1'b1;
                pc_d    = RESET_PC;
                state_d = RUN;
            end
            RUN: begin
                if (redir_any && stall) begin
                    pend_pc_d = win_pc;
                    pend_v_d  = 1'b1;
                    state_d   = HOLD;
                end else if (redir_any) begin
                    pc_d    = win_pc;
                    valid_d = 1'b1;
                end else if (hs) begin
                    pc_d = use_pred ? btb_tgt : pc_q + XLEN'(4);
                end
            end
            HOLD: begin
                if (hs) begin
                    pc_d     = redir_any ? win_pc : pend_pc_q;
                    pend_v_d = 1'b0;
                    state_d  = RUN;
                end else if (redir_any) begin
                    pend_pc_d = win_pc;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: sequential fetch, redirects,
// stall hold, priority, wrap, reset during hold and (optionally) the BTB.
module tb_pc_gen;

    logic              clk;
    logic              reset;
    logic [2:0]        redirect_valid;
    logic [2:0][63:0]  redirect_pc;
    logic              pc_ready;
    logic              pc_valid;
    logic [63:0]       pc;
    logic              pc_kill;
    logic              pred_taken;
    logic              train_valid;
    logic [63:0]       train_pc;
    logic [63:0]       train_target;

    int n_tests;
    int n_fail;

    pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_ready       (pc_ready),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .pc_kill        (pc_kill),
        .pred_taken     (pred_taken),
        .train_valid    (train_valid),
        .train_pc       (train_pc),
        .train_target   (train_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_tests++;
        if (pc !== 64'h8000_0000) begin
            $display("FAIL reset_pc got=%h exp=%h", pc, 64'h8000_0000);
            n_fail++;
        end
        n_tests++;
        if (pc_valid !== 1'b0 || pc_kill !== 1'b0 || pred_taken !== 1'b0) begin
            $display("FAIL reset_flags got v=%b k=%b p=%b exp 0 0 0",
                     pc_valid, pc_kill, pred_taken);
            n_fail++;
        end
        step;
        reset    = 1'b0;
        pc_ready = 1'b1;
        #1;
        n_tests++;
        if (pc_valid !== 1'b0) begin
            $display("FAIL boot_valid got=%b exp=0", pc_valid);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc_valid !== 1'b1 || pc !== 64'h8000_0000) begin
            $display("FAIL boot_first got v=%b pc=%h exp v=1 pc=%h",
                     pc_valid, pc, 64'h8000_0000);
            n_fail++;
        end
    endtask

    task automatic test_seq;
        n_tests++;
        if (pc_kill !== 1'b0) begin
            $display("FAIL seq_kill0 got=%b exp=0", pc_kill);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_0004) begin
            $display("FAIL seq_pc1 got=%h exp=%h", pc, 64'h8000_0004);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_0008 || pc_kill !== 1'b0) begin
            $display("FAIL seq_pc2 got pc=%h k=%b exp pc=%h k=0",
                     pc, pc_kill, 64'h8000_0008);
            n_fail++;
        end
    endtask

    task automatic test_redirect;
        redirect_valid = 3'b100;
        redirect_pc[2] = 64'h8000_1001;
        #1;
        n_tests++;
        if (pc_kill !== 1'b1) begin
            $display("FAIL redir_kill got=%b exp=1", pc_kill);
            n_fail++;
        end
        step;
        redirect_valid = 3'b000;
        #1;
        n_tests++;
        if (pc !== 64'h8000_1000 || pc_kill !== 1'b0) begin
            $display("FAIL redir_pc got pc=%h k=%b exp pc=%h k=0",
                     pc, pc_kill, 64'h8000_1000);
            n_fail++;
        end
    endtask

    task automatic test_stall;
        pc_ready       = 1'b0;
        redirect_valid = 3'b010;
        redirect_pc[1] = 64'h8000_2000;
        #1;
        n_tests++;
        if (pc_kill !== 1'b0) begin
            $display("FAIL stall_kill got=%b exp=0", pc_kill);
            n_fail++;
        end
        step;
        redirect_valid = 3'b100;
        redirect_pc[2] = 64'h8000_3000;
        #1;
        n_tests++;
        if (pc !== 64'h8000_1000 || pc_valid !== 1'b1) begin
            $display("FAIL stall_hold1 got pc=%h v=%b exp pc=%h v=1",
                     pc, pc_valid, 64'h8000_1000);
            n_fail++;
        end
        step;
        redirect_valid = 3'b000;
        step;
        n_tests++;
        if (pc !== 64'h8000_1000) begin
            $display("FAIL stall_hold3 got=%h exp=%h", pc, 64'h8000_1000);
            n_fail++;
        end
        pc_ready = 1'b1;
        #1;
        n_tests++;
        if (pc_kill !== 1'b1) begin
            $display("FAIL stall_kill_rel got=%b exp=1", pc_kill);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_3000 || pc_kill !== 1'b0) begin
            $display("FAIL stall_release got pc=%h k=%b exp pc=%h k=0",
                     pc, pc_kill, 64'h8000_3000);
            n_fail++;
        end
    endtask

    task automatic test_priority;
        redirect_valid = 3'b101;
        redirect_pc[0] = 64'h8000_0100;
        redirect_pc[2] = 64'h8000_9000;
        step;
        redirect_valid = 3'b000;
        #1;
        n_tests++;
        if (pc !== 64'h8000_0100) begin
            $display("FAIL prio_pc got=%h exp=%h", pc, 64'h8000_0100);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        pc_ready       = 1'b0;
        redirect_valid = 3'b001;
        redirect_pc[0] = 64'h8000_0200;
        step;
        redirect_valid = 3'b010;
        redirect_pc[1] = 64'h8000_0300;
        pc_ready       = 1'b1;
        step;
        redirect_valid = 3'b000;
        #1;
        n_tests++;
        if (pc !== 64'h8000_0300) begin
            $display("FAIL hold_exit_redir got=%h exp=%h", pc, 64'h8000_0300);
            n_fail++;
        end
    endtask

    task automatic test_wrap;
        redirect_valid = 3'b001;
        redirect_pc[0] = 64'hFFFF_FFFF_FFFF_FFFD;
        step;
        redirect_valid = 3'b000;
        #1;
        n_tests++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            $display("FAIL wrap_top got=%h exp=%h", pc, 64'hFFFF_FFFF_FFFF_FFFC);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h0) begin
            $display("FAIL wrap_zero got=%h exp=%h", pc, 64'h0);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h4) begin
            $display("FAIL wrap_four got=%h exp=%h", pc, 64'h4);
            n_fail++;
        end
    endtask

    task automatic test_reset_hold;
        pc_ready       = 1'b0;
        redirect_valid = 3'b100;
        redirect_pc[2] = 64'h8000_5000;
        step;
        redirect_valid = 3'b000;
        reset          = 1'b1;
        #1;
        n_tests++;
        if (pc !== 64'h8000_0000 || pc_valid !== 1'b0) begin
            $display("FAIL rsthold_pc got pc=%h v=%b exp pc=%h v=0",
                     pc, pc_valid, 64'h8000_0000);
            n_fail++;
        end
        step;
        reset    = 1'b0;
        pc_ready = 1'b1;
        step;
        n_tests++;
        if (pc !== 64'h8000_0000 || pc_valid !== 1'b1 || pc_kill !== 1'b0) begin
            $display("FAIL rsthold_boot got pc=%h v=%b k=%b exp pc=%h v=1 k=0",
                     pc, pc_valid, pc_kill, 64'h8000_0000);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_0004) begin
            $display("FAIL rsthold_lost got=%h exp=%h", pc, 64'h8000_0004);
            n_fail++;
        end
    endtask

    task automatic test_btb;
        train_valid  = 1'b1;
        train_pc     = 64'h8000_0008;
        train_target = 64'h8000_0400;
        step;
        train_valid = 1'b0;
        #1;
`ifdef PCGEN_BTB_EN
        n_tests++;
        if (pc !== 64'h8000_0008 || pred_taken !== 1'b1) begin
            $display("FAIL btb_hit got pc=%h p=%b exp pc=%h p=1",
                     pc, pred_taken, 64'h8000_0008);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_0400 || pred_taken !== 1'b0) begin
            $display("FAIL btb_target got pc=%h p=%b exp pc=%h p=0",
                     pc, pred_taken, 64'h8000_0400);
            n_fail++;
        end
`else
        n_tests++;
        if (pc !== 64'h8000_0008 || pred_taken !== 1'b0) begin
            $display("FAIL nobtb_pred got pc=%h p=%b exp pc=%h p=0",
                     pc, pred_taken, 64'h8000_0008);
            n_fail++;
        end
        step;
        n_tests++;
        if (pc !== 64'h8000_000C) begin
            $display("FAIL nobtb_seq got=%h exp=%h", pc, 64'h8000_000C);
            n_fail++;
        end
`endif
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        pc_ready       = 1'b0;
        redirect_valid = 3'b000;
        redirect_pc    = '0;
        train_valid    = 1'b0;
        train_pc       = '0;
        train_target   = '0;
        test_reset;
        test_seq;
        test_redirect;
        test_stall;
        test_priority;
        test_back_to_back;
        test_wrap;
        test_reset_hold;
        test_btb;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation fetch PC generator. Replaces the purely combinational next-PC mux with a registered PC, N prioritised redirect channels, and a valid/ready request handshake toward the instruction-memory interface.
- Holds a redirect that arrives while a request is stalled. Flags wrong-path requests for the IF stage to discard.
- Sits at the head of the fetch stage. Redirect sources are trap/MRET, CSR flush, and EX branch/JALR.

Parameters:
- XLEN, 64, PC width.
- NUM_REDIRECT, 3, number of redirect channels; index 0 has highest priority.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address.
- BTB_ENTRIES, 16, BTB depth; power of two; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  NUM_REDIRECT  per-channel redirect request
- redirect_pc  in  NUM_REDIRECT x XLEN  per-channel target
- pc_ready  in  1  IF/imem accepts the current request
- pc_valid  out  1  request valid
- pc  out  XLEN  request address
- pc_kill  out  1  accepted request is wrong-path; IF drops its instruction
- pred_taken  out  1  BTB predicted the next PC after this request
- train_valid  in  1  BTB update strobe from EX
- train_pc  in  XLEN  branch PC
- train_target  in  XLEN  resolved taken target

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC, pc_valid = 0, pc_kill = 0, pred_taken = 0.
  - pend_v = 0.
  - state = BOOT.
- State machine:
  - BOOT -> RUN on the first clock after reset deasserts. pc_valid becomes 1 with pc = RESET_PC.
  - RUN -> HOLD when a redirect is seen while pc_valid && !pc_ready.
  - HOLD -> RUN on the handshake (pc_valid && pc_ready).
- Handshake rule: while pc_valid && !pc_ready, pc and pc_valid stay stable. Redirects never change an unaccepted request.
- Winner selection: the lowest-index asserted redirect_valid wins. Its target has bit 0 cleared.
- RUN, redirect, no stall (handshake or !pc_valid): pc <= winner target next cycle. Latency is 1 cycle.
- RUN, redirect during stall: pend_pc <= winner, pend_v <= 1, go to HOLD.
- HOLD, later redirect: it overwrites pend_pc. The most recent redirect always wins.
- HOLD exit: on handshake, pc <= pend_pc and pend_v <= 0. If a redirect arrives in the same cycle as the handshake, it takes precedence over pend_pc.
- pc_kill: combinational, asserted on a handshake cycle when (any redirect_valid || pend_v). It is never asserted without pc_ready.
- Sequential advance: on handshake with no redirect and no pending redirect, pc <= pc + 4, modulo 2^XLEN. The wrap from all-ones-minus-3 to 0 is legal.
- No handshake and no redirect: all state is held.
- Reset mid-HOLD: the pending redirect is discarded and state returns to BOOT.

Optional Feature:
- Macro: PCGEN_BTB_EN.
- Enabled:
  - Direct-mapped BTB of BTB_ENTRIES entries, indexed by pc[log2(BTB_ENTRIES)+1:2]; each entry holds a tag (remaining upper bits), a target and a valid bit.
  - On a sequential handshake with a hit, the next pc = entry target and pred_taken = 1 for that cycle.
  - train_valid writes the entry on the next clock edge. A same-cycle read of the same index sees the old contents.
  - Reset clears all valid bits.
  - Redirect and pending logic override any prediction.
- Disabled: no BTB storage, pred_taken tied to 0, train_* ignored. Ports remain present.

Decomposition:
- Shared pipes package: redirect channel index constants (REDIR_TRAP = 0, REDIR_CSR = 1, REDIR_BRANCH = 2), pc_gen state enum (BOOT, RUN, HOLD), and a btb_entry_t struct (tag, target, valid).
- One sub-module, pc_btb: BTB storage with lookup and train, instantiated only under PCGEN_BTB_EN.

Test Plan:
- Reset release, pc_ready = 1 -> cycle 1: pc = 0x80000000, pc_valid = 1; then 0x80000004, 0x80000008; pc_kill = 0.
- Redirect on ch2 to 0x80001001 with pc_ready = 1 -> next pc = 0x80001000; pc_kill = 1 on that handshake cycle.
- pc_ready = 0 for 3 cycles; ch1 redirect to 0x80002000, then ch2 to 0x80003000 -> pc held stable; after ready, pc_kill = 1 and next pc = 0x80003000.
- Simultaneous ch0 = 0x80000100 and ch2 = 0x80009000 -> next pc = 0x80000100.
- pc = 0xFFFFFFFFFFFFFFFC with handshake -> next pc = 0x0.
- With PCGEN_BTB_EN: train 0x80000008 -> 0x80000400, then fetch 0x80000008 -> pred_taken = 1 and next pc = 0x80000400. Reset during HOLD -> pc = 0x80000000 and the pending redirect is lost.
